// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder front end: synchronises and debounces A/B/Z on sample ticks,
// decodes x4 quadrature into a signed position, direction, step, error and velocity.
module quad_encoder_decoder #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned VEL_WIN  = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_clk,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    enc_z,
    input  logic                    index_clr_en,
    input  logic                    pos_clr,
    output logic signed [CNT_W-1:0] position,
    output logic                    dir,
    output logic                    step,
    output logic                    err,
    output logic signed [CNT_W-1:0] velocity,
    output logic                    vel_valid
);

    localparam int unsigned FC_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam int unsigned WC_W = $clog2(VEL_WIN);
    localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    // Channel vectors are ordered {z, b, a}
    logic [2:0]            sync1_q, sync2_q, filt_q, filt_nxt;
    logic [2:0][FC_W-1:0]  fcnt_q, fcnt_nxt;
    logic                  sample_clk_q, init_q;
    logic                  tick_c, dec_en_c, fwd_c, rev_c, bad_c, step_c, idx_clr_c, win_last_c;
    logic [1:0]            idx_old_c, idx_new_c;
    logic signed [CNT_W-1:0] acc_q, acc_nxt;
    logic [WC_W-1:0]       win_q;

    assign tick_c = sample_clk & ~sample_clk_q;

    // Run-length debounce; the first tick after reset loads the filters directly
    always_comb begin
        filt_nxt = filt_q;
        fcnt_nxt = fcnt_q;
        for (int i = 0; i < 3; i++) begin
            if (tick_c) begin
                if (!init_q) begin
                    filt_nxt[i] = sync2_q[i];
                    fcnt_nxt[i] = '0;
                end else if (sync2_q[i] == filt_q[i]) begin
                    fcnt_nxt[i] = '0;
                end else if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
                    filt_nxt[i] = sync2_q[i];
                    fcnt_nxt[i] = '0;
                end else begin
                    fcnt_nxt[i] = fcnt_q[i] + FC_W'(1);
                end
            end
        end
    end

    // AB mapped onto a 2-bit Gray position so forward is +1 mod 4
    always_comb begin
        idx_old_c  = {filt_q[1], filt_q[1] ^ filt_q[0]};
        idx_new_c  = {filt_nxt[1], filt_nxt[1] ^ filt_nxt[0]};
        dec_en_c   = tick_c & init_q;
        fwd_c      = dec_en_c & (idx_new_c == idx_old_c + 2'd1);
        rev_c      = dec_en_c & (idx_old_c == idx_new_c + 2'd1);
        bad_c      = dec_en_c & ((filt_nxt[1:0] ^ filt_q[1:0]) == 2'b11);
        step_c     = fwd_c | rev_c;
        idx_clr_c  = dec_en_c & index_clr_en & filt_nxt[2] & ~filt_q[2];
        win_last_c = tick_c & (win_q == WC_W'(VEL_WIN - 1));
        acc_nxt    = acc_q;
        if (fwd_c && acc_q != ACC_MAX) begin
            acc_nxt = acc_q + CNT_W'(1);
        end else if (rev_c && acc_q != ACC_MIN) begin
            acc_nxt = acc_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sample_clk_q <= 1'b0;
            filt_q       <= '0;
            fcnt_q       <= '0;
            init_q       <= 1'b0;
            acc_q        <= '0;
            win_q        <= '0;
            position     <= '0;
            dir          <= 1'b0;
            step         <= 1'b0;
            err          <= 1'b0;
            velocity     <= '0;
            vel_valid    <= 1'b0;
        end else begin
            sync1_q      <= {enc_z, enc_b, enc_a};
            sync2_q      <= sync1_q;
            sample_clk_q <= sample_clk;
            step         <= step_c;
            vel_valid    <= 1'b0;
            if (tick_c) begin
                filt_q <= filt_nxt;
                fcnt_q <= fcnt_nxt;
                init_q <= 1'b1;
                if (step_c) begin
                    dir <= fwd_c;
                end
                if (bad_c) begin
                    err <= 1'b1;
                end
                if (idx_clr_c) begin
                    position <= '0;
                end else if (fwd_c) begin
                    position <= position + CNT_W'(1);
                end else if (rev_c) begin
                    position <= position - CNT_W'(1);
                end
                if (win_last_c) begin
                    velocity  <= acc_nxt;
                    acc_q     <= '0;
                    win_q     <= '0;
                    vel_valid <= 1'b1;
                end else begin
                    acc_q <= acc_nxt;
                    win_q <= win_q + WC_W'(1);
                end
            end
            // Clear wins over index and step, with or without a tick
            if (pos_clr) begin
                position <= '0;
                err      <= 1'b0;
                acc_q    <= '0;
                win_q    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Scoreboard bench for quad_encoder_decoder: a phase-level encoder model queues
// expected step and velocity events, a monitor pops them as the DUT pulses.
module tb_quad_encoder_decoder;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned FILT_LEN = 3;
    localparam int unsigned VEL_WIN  = 10;
    localparam int          ACC_MAXI = 127;
    localparam int          ACC_MINI = -128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_clk = 1'b0;
    logic enc_a = 1'b1, enc_b = 1'b1, enc_z = 1'b0;
    logic index_clr_en = 1'b0;
    logic pos_clr = 1'b0;
    logic signed [CNT_W-1:0] position, velocity;
    logic dir, step, err, vel_valid;

    typedef struct {
        logic signed [CNT_W-1:0] pos;
        logic                    dir;
        int                      tick;
    } step_exp_t;

    step_exp_t               sq[$];
    logic signed [CNT_W-1:0] vq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int g_tick = 0;

    // Model state; m_ab is {a, b}
    logic [1:0]              m_ab = 2'b11;
    logic                    m_z = 1'b0;
    logic                    m_init = 1'b0;
    logic signed [CNT_W-1:0] m_pos = '0;
    logic                    m_dir = 1'b0;
    logic                    m_err = 1'b0;
    int                      m_acc = 0;
    int                      m_win = 0;

    quad_encoder_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .VEL_WIN(VEL_WIN)) dut (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk),
        .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .index_clr_en(index_clr_en), .pos_clr(pos_clr),
        .position(position), .dir(dir), .step(step), .err(err),
        .velocity(velocity), .vel_valid(vel_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_window(input int d);
        if (d > 0 && m_acc != ACC_MAXI) m_acc++;
        else if (d < 0 && m_acc != ACC_MINI) m_acc--;
        if (m_win == int'(VEL_WIN) - 1) begin
            vq.push_back(CNT_W'(m_acc));
            m_acc = 0;
            m_win = 0;
        end else begin
            m_win++;
        end
    endtask

    // Present a phase, let the synchroniser settle, then issue n ticks
    task automatic hold_phase(input logic [1:0] ab, input logic z, input int n);
        int d;
        step_exp_t e;
        @(negedge clk);
        enc_a = ab[1];
        enc_b = ab[0];
        enc_z = z;
        repeat (3) @(negedge clk);
        for (int k = 1; k <= n; k++) begin
            d = 0;
            sample_clk = 1'b1;
            g_tick++;
            if (!m_init) begin
                if (k == 1) begin
                    m_ab = ab;
                    m_z = z;
                    m_init = 1'b1;
                end
            end else if (k == int'(FILT_LEN)) begin
                if (ab == fwd_of(m_ab)) d = 1;
                else if (ab == rev_of(m_ab)) d = -1;
                else if (ab != m_ab) m_err = 1'b1;
                if (d != 0) m_dir = (d > 0);
                if (index_clr_en && z && !m_z) m_pos = '0;
                else m_pos = m_pos + CNT_W'(d);
                if (d != 0) begin
                    e.pos = m_pos;
                    e.dir = m_dir;
                    e.tick = g_tick;
                    sq.push_back(e);
                end
                m_ab = ab;
                m_z = z;
            end
            model_window(d);
            @(negedge clk);
            sample_clk = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_pos_clr();
        @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        m_pos = '0;
        m_err = 1'b0;
        m_acc = 0;
        m_win = 0;
    endtask

    // Monitor: every step / vel_valid pulse must match the head of its queue
    step_exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (step) begin
                if (sq.size() == 0) begin
                    check_eq("step_unexpected", 32'(step), 32'd0);
                end else begin
                    mon_e = sq.pop_front();
                    check_eq("step_pos", position, mon_e.pos);
                    check_eq("step_dir", 32'(dir), 32'(mon_e.dir));
                    check_eq("step_tick", g_tick, mon_e.tick);
                end
            end
            if (vel_valid) begin
                if (vq.size() == 0) check_eq("vel_unexpected", 32'(vel_valid), 32'd0);
                else check_eq("velocity", velocity, vq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_position", position, 32'd0);
        check_eq("rst_dir", 32'(dir), 32'd0);
        check_eq("rst_step", 32'(step), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_velocity", velocity, 32'd0);
        check_eq("rst_vel_valid", 32'(vel_valid), 32'd0);
        rst_n = 1'b1;

        // Init load at AB=11, no step
        hold_phase(2'b11, 1'b0, 10);
        check_eq("init_position", position, m_pos);
        check_eq("init_err", 32'(err), 32'd0);

        // Walk to 00, then clear and run a full forward cycle
        hold_phase(2'b01, 1'b0, 4);
        hold_phase(2'b00, 1'b0, 4);
        do_pos_clr();
        check_eq("clr_position", position, 32'd0);
        hold_phase(2'b10, 1'b0, 4);
        hold_phase(2'b11, 1'b0, 4);
        hold_phase(2'b01, 1'b0, 4);
        hold_phase(2'b00, 1'b0, 4);
        check_eq("fwd_position", position, 32'd4);
        check_eq("fwd_dir", 32'(dir), 32'd1);
        for (int i = 0; i < 8; i++) hold_phase(rev_of(m_ab), 1'b0, 4);
        check_eq("rev_position", position, 32'(-4));
        check_eq("rev_dir", 32'(dir), 32'd0);

        // Short glitch on A is rejected; next real change needs a full run
        hold_phase(2'b10, 1'b0, 2);
        hold_phase(2'b00, 1'b0, 4);
        check_eq("glitch_position", position, 32'(-4));
        hold_phase(2'b10, 1'b0, int'(FILT_LEN));
        check_eq("after_glitch_position", position, m_pos);

        // Illegal 00 -> 11 jump
        hold_phase(2'b00, 1'b0, 4);
        hold_phase(2'b11, 1'b0, 3);
        check_eq("err_set", 32'(err), 32'd1);
        check_eq("err_position", position, m_pos);
        do_pos_clr();
        check_eq("err_cleared", 32'(err), 32'd0);
        check_eq("err_clr_position", position, 32'd0);

        // Wrap past the positive limit
        for (int i = 0; i < 127; i++) hold_phase(fwd_of(m_ab), 1'b0, int'(FILT_LEN));
        check_eq("pos_max", position, 32'h7F);
        hold_phase(fwd_of(m_ab), 1'b0, int'(FILT_LEN));
        check_eq("pos_wrap", position, 32'(-128));

        // Index edge together with a step clears position, step still pulses
        index_clr_en = 1'b1;
        hold_phase(fwd_of(m_ab), 1'b1, 4);
        check_eq("index_position", position, 32'd0);
        check_eq("index_dir", 32'(dir), 32'd1);
        hold_phase(fwd_of(m_ab), 1'b0, 4);
        check_eq("index_fall_position", position, 32'd1);
        index_clr_en = 1'b0;
        hold_phase(fwd_of(m_ab), 1'b1, 4);
        check_eq("index_off_position", position, 32'd2);
        hold_phase(fwd_of(m_ab), 1'b0, 4);

        // Velocity windows: +3 then -2
        do_pos_clr();
        for (int i = 0; i < 3; i++) hold_phase(fwd_of(m_ab), 1'b0, int'(FILT_LEN));
        hold_phase(m_ab, 1'b0, 1);
        check_eq("vel_plus3", velocity, 32'd3);
        for (int i = 0; i < 2; i++) hold_phase(rev_of(m_ab), 1'b0, int'(FILT_LEN));
        hold_phase(m_ab, 1'b0, 4);
        check_eq("vel_minus2", velocity, 32'(-2));

        // No ticks: input movement must not be decoded
        @(negedge clk);
        enc_a = fwd_of(m_ab) >> 1;
        enc_b = fwd_of(m_ab) & 2'b01;
        repeat (20) @(negedge clk);
        check_eq("freeze_position", position, m_pos);
        hold_phase(m_ab, m_z, 4);
        check_eq("freeze_resume_position", position, m_pos);

        check_eq("step_queue_left", sq.size(), 32'd0);
        check_eq("vel_queue_left", vq.size(), 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_position", position, 32'd0);
        check_eq("async_rst_dir", 32'(dir), 32'd0);
        check_eq("async_rst_velocity", velocity, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
